// File: rtl/lfsr_chk_pkg.sv
// Shared types and constants for the LFSR period checker.
// The LOCKUP state exists only when LFSR_CHK_LOCKUP_EN is defined.
package lfsr_chk_pkg;

  localparam int unsigned LFSR_CHK_WIDTH = 6;
  localparam int unsigned LFSR_CHK_LIMIT = 2 ** LFSR_CHK_WIDTH;

`ifdef LFSR_CHK_LOCKUP_EN
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COUNT   = 3'd1,
    ST_DONE    = 3'd2,
    ST_TIMEOUT = 3'd3,
    ST_LOCKUP  = 3'd4
  } state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COUNT   = 3'd1,
    ST_DONE    = 3'd2,
    ST_TIMEOUT = 3'd3
  } state_e;
`endif

endpackage

// File: rtl/lfsr_chk_cnt.sv
// Saturating comparison counter: loads 1, increments, flags the 2**WIDTH limit.
module lfsr_chk_cnt
  import lfsr_chk_pkg::*;
#(
  parameter int unsigned WIDTH = LFSR_CHK_WIDTH
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load,
  input  logic           inc,
  output logic [WIDTH:0] cnt,
  output logic           at_limit
);

  localparam logic [WIDTH:0] LIMIT = {1'b1, {WIDTH{1'b0}}};
  localparam logic [WIDTH:0] ONE   = {{WIDTH{1'b0}}, 1'b1};

  logic [WIDTH:0] cnt_q, cnt_d;

  assign at_limit = (cnt_q == LIMIT);
  assign cnt      = cnt_q;

  always_comb begin
    // NOTE: defaulting to the held value first keeps this combinational (no latch).
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = ONE;
    end else if (inc && !at_limit) begin
      cnt_d = cnt_q + ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values regardless of order.
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/lfsr_period_checker.sv
// Measures how many clk cycles an upstream LFSR takes to return to a captured state.
// Define LFSR_CHK_LOCKUP_EN to add all-zero lockup detection; otherwise lockup is 0.
module lfsr_period_checker
  import lfsr_chk_pkg::*;
#(
  parameter int unsigned WIDTH = LFSR_CHK_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] d_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   period,
  output logic             timeout,
  output logic             lockup
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] ref_q, ref_d;
  logic [WIDTH:0]   period_q, period_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             timeout_q, timeout_d;
  logic             cnt_load, cnt_inc, cnt_at_limit;
  logic [WIDTH:0]   cnt;

  lfsr_chk_cnt #(.WIDTH(WIDTH)) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .inc      (cnt_inc),
    .cnt      (cnt),
    .at_limit (cnt_at_limit)
  );

  always_comb begin
    state_d  = state_q;
    ref_d    = ref_q;
    period_d = period_q;
    cnt_load = 1'b0;
    cnt_inc  = 1'b0;
`ifdef LFSR_CHK_LOCKUP_EN
    if ((start || state_q == ST_COUNT) && d_in == '0) begin
      state_d = ST_LOCKUP;
    end else
`endif
    // start behaves the same from every state, including a restart mid-count
    if (start) begin
      state_d  = ST_COUNT;
      ref_d    = d_in;
      cnt_load = 1'b1;
    end else if (state_q == ST_COUNT) begin
      if (d_in == ref_q) begin
        period_d = cnt;
        state_d  = ST_DONE;
      end else if (cnt_at_limit) begin
        state_d = ST_TIMEOUT;
      end else begin
        cnt_inc = 1'b1;
      end
    end
  end

  assign busy_d    = (state_d == ST_COUNT);
  assign done_d    = (state_d == ST_DONE);
  assign timeout_d = (state_d == ST_TIMEOUT);

`ifdef LFSR_CHK_LOCKUP_EN
  logic lockup_q, lockup_d;
  assign lockup_d = (state_d == ST_LOCKUP);
  assign lockup   = lockup_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lockup_q <= 1'b0;
    end else begin
      lockup_q <= lockup_d;
    end
  end
`else
  assign lockup = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ref_q     <= '0;
      period_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ref_q     <= ref_d;
      period_q  <= period_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign period  = period_q;
  assign timeout = timeout_q;

endmodule
